// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = a - b - bin over WIDTH cycles using a
// single full-subtractor cell and a registered borrow. start/busy/done handshake.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] r_sr_q, r_sr_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  // Full-subtractor cell on the current LSBs.
  logic             x, y, d, br_next;
  logic [WIDTH-1:0] r_next;

  assign x       = a_sr_q[0];
  assign y       = b_sr_q[0];
  assign d       = x ^ y ^ br_q;
  assign br_next = (~x & y) | (~x & br_q) | (y & br_q);
  assign r_next  = {d, r_sr_q[WIDTH-1:1]};

  // Outputs come straight from registers; no input reaches an output combinationally.
  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;

  // Next-state and datapath updates for the three-state sequencer.
  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    r_sr_d  = r_sr_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          br_d    = bin;
          cnt_d   = '0;
          r_sr_d  = '0;
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        r_sr_d = r_next;
        br_d   = br_next;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          // Results take the final bit directly so they are valid on DONE entry.
          state_d = DONE;
          diff_d  = r_next;
          bout_d  = br_next;
          ovf_d   = (a_msb_q ^ b_msb_q) & (d ^ a_msb_q);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      r_sr_q  <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      r_sr_q  <= r_sr_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and back-to-back random checks for serial_subtractor at WIDTH=8.
module tb_serial_subtractor;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       bout;
  logic       ovf;

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Independent reference: integer arithmetic, overflow from signed range.
  task automatic ref_model(input logic [7:0] av, input logic [7:0] bv, input logic bi,
                           output logic [7:0] ed, output logic eb, output logic eo);
    int u, s;
    u  = int'(av) - int'(bv) - int'(bi);
    s  = int'($signed(av)) - int'($signed(bv)) - int'(bi);
    ed = u[7:0];
    eb = (u < 0);
    eo = (s > 127) || (s < -128);
  endtask

  // One operation from idle; checks latency, busy length, results and return to idle.
  task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic bi, input logic [7:0] ed, input logic eb, input logic eo);
    int j, busy_cnt;
    @(negedge clk);
    a = av; b = bv; bin = bi; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    j = 0; busy_cnt = 0;
    while (!done && j < 20) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      j++;
    end
    if (busy) busy_cnt++;
    check_eq({tag, "_latency"}, j, 8);
    check_eq({tag, "_diff"}, diff, ed);
    check_eq({tag, "_bout"}, bout, eb);
    check_eq({tag, "_ovf"}, ovf, eo);
    check_eq({tag, "_busy_cycles"}, busy_cnt, 9);
    @(negedge clk);
    check_eq({tag, "_done_fall"}, done, 0);
    check_eq({tag, "_busy_fall"}, busy, 0);
  endtask

  initial begin
    int j, dones;
    logic [7:0] ca, cb, ed;
    logic       cbi, eb, eo;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_diff", diff, 0);
    check_eq("rst_bout", bout, 0);
    check_eq("rst_ovf", ovf, 0);
    rst_n = 1'b1;

    run_op("basic", 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0);
    run_op("underflow", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
    run_op("ovf_neg", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    run_op("bin", 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0);
    run_op("ovf_pos", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);

    // start pulses during SHIFT and DONE are ignored
    @(negedge clk);
    a = 8'h5A; b = 8'h3C; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    for (int k = 0; k < 9; k++) begin
      if (k == 3) begin start = 1'b1; a = 8'hFF; b = 8'h00; end
      if (k == 4) start = 1'b0;
      if (k == 8) start = 1'b1;
      if (done) dones++;
      @(negedge clk);
    end
    check_eq("ign_diff", diff, 8'h1E);
    check_eq("ign_dones", dones, 1);
    check_eq("ign_idle_gap", busy, 0);
    @(negedge clk);
    start = 1'b0;
    check_eq("ign_reaccept", busy, 1);
    j = 0;
    while (!done && j < 20) begin @(negedge clk); j++; end
    check_eq("ign2_latency", j, 8);
    check_eq("ign2_diff", diff, 8'hFF);
    @(negedge clk);

    // reset asserted at the 4th SHIFT edge
    @(negedge clk);
    a = 8'h5A; b = 8'h3C; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_done", done, 0);
    check_eq("mid_rst_diff", diff, 0);
    check_eq("mid_rst_bout", bout, 0);
    check_eq("mid_rst_ovf", ovf, 0);
    dones = 0;
    for (int k = 0; k < 12; k++) begin
      if (done) dones++;
      @(negedge clk);
    end
    check_eq("mid_rst_no_done", dones, 0);
    run_op("after_rst", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);

    // start held high, operands changing every cycle: acceptances every 10 cycles
    ca = '0; cb = '0; cbi = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      check_eq("b2b_done", done, (c % 10 == 9));
      if (c % 10 == 9) begin
        ref_model(ca, cb, cbi, ed, eb, eo);
        check_eq("b2b_diff", diff, ed);
        check_eq("b2b_bout", bout, eb);
        check_eq("b2b_ovf", ovf, eo);
      end
      start = 1'b1;
      a   = 8'($urandom);
      b   = 8'($urandom);
      bin = 1'($urandom);
      if (c % 10 == 0) begin ca = a; cb = b; cbi = bin; end
      @(negedge clk);
    end
    start = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
